// File: rtl/hazard_pkg.sv
// Package: hazard_pkg
// Scoreboard entry type, forwarding-select constants and small helpers
// shared by pipeline_hazard_unit and hazard_src_match.
package hazard_pkg;

  // Widest register index a scoreboard entry can hold; REG_ADDR_W must not exceed it.
  localparam int unsigned SB_RD_W = 8;

  // Forwarding select value meaning "take the operand from the register file".
  localparam int unsigned FWD_SEL_REGFILE = 0;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               we;
    logic               load;
  } sb_entry_t;

  // Width of a forwarding select able to name regfile plus fwd_depth stages.
  function automatic int unsigned sel_width(input int unsigned fwd_depth);
    return (fwd_depth < 1) ? 1 : $clog2(fwd_depth + 1);
  endfunction

  // True when entry e will write the register that source src reads.
  // x0 is hard-wired to zero, so it never produces a hit.
  function automatic logic entry_hit(input sb_entry_t          e,
                                     input logic [SB_RD_W-1:0] src,
                                     input logic               used);
    return e.valid && e.we && used && (src != '0) && (e.rd == src);
  endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Module: hazard_src_match
// Compares one source operand against every scoreboard stage and returns
// the youngest forwarding stage plus a flag for a too-young load producer.
module hazard_src_match
  import hazard_pkg::*;
#(
  parameter  int unsigned REG_ADDR_W = 5,
  parameter  int unsigned FWD_DEPTH  = 2,
  parameter  int unsigned LOAD_STAGE = 2,
  localparam int unsigned SEL_W      = sel_width(FWD_DEPTH)
) (
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic                  src_used,
  input  sb_entry_t             sb [0:FWD_DEPTH],
  output logic [SEL_W-1:0]      fwd_sel,
  output logic                  load_hit
);

  logic [SB_RD_W-1:0] src_ext;

  assign src_ext = SB_RD_W'(src_addr);

  // Youngest post-EX hit wins the select; loads not yet at LOAD_STAGE raise load_hit.
  always_comb begin
    // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
    fwd_sel  = SEL_W'(FWD_SEL_REGFILE);
    load_hit = 1'b0;
    // Walk oldest to youngest so the smallest matching stage is written last.
    for (int k = int'(FWD_DEPTH); k >= 1; k--) begin
      if (entry_hit(sb[k], src_ext, src_used)) begin
        fwd_sel = SEL_W'(k);
      end
    end
    for (int j = 0; j <= int'(FWD_DEPTH); j++) begin
      if ((j <= int'(LOAD_STAGE) - 2) && sb[j].load && entry_hit(sb[j], src_ext, src_used)) begin
        load_hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Module: pipeline_hazard_unit
// Forwarding selects, load-use stall/bubble and taken-branch flushes for an
// in-order pipeline, driven from a scoreboard of in-flight destination writes.
// Optional feature macro: HAZARD_PERF_CNT_EN enables the stall/flush counters;
// without it both counter outputs are tied to zero.
module pipeline_hazard_unit
  import hazard_pkg::*;
#(
  parameter  int unsigned REG_ADDR_W   = 5,
  parameter  int unsigned NUM_RD_PORTS = 2,
  parameter  int unsigned FWD_DEPTH    = 2,
  parameter  int unsigned LOAD_STAGE   = 2,
  localparam int unsigned SEL_W        = sel_width(FWD_DEPTH)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               id_valid,
  input  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] id_rs_addr,
  input  logic [NUM_RD_PORTS-1:0]            id_rs_used,
  input  logic [REG_ADDR_W-1:0]              id_rd,
  input  logic                               id_reg_write,
  input  logic                               id_mem_read,
  input  logic                               branch_taken,
  output logic                               pc_write_en,
  output logic                               if_id_write_en,
  output logic                               id_ex_bubble,
  output logic                               if_id_flush,
  output logic                               id_ex_flush,
  output logic                               ex_mem_flush,
  output logic [NUM_RD_PORTS*SEL_W-1:0]      fwd_sel,
  output logic [31:0]                        stall_cnt,
  output logic [31:0]                        flush_cnt
);

  // Stage 0 is the instruction in EX; higher indices are older instructions.
  sb_entry_t                          sb_q [0:FWD_DEPTH];
  sb_entry_t                          sb_d [0:FWD_DEPTH];
  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] ex_rs_addr_q, ex_rs_addr_d;
  logic [NUM_RD_PORTS-1:0]            ex_rs_used_q, ex_rs_used_d;

  logic [NUM_RD_PORTS-1:0]            id_load_hit;
  logic [NUM_RD_PORTS-1:0]            ex_load_hit_unused;
  logic [NUM_RD_PORTS*SEL_W-1:0]      id_fwd_sel_unused;
  logic                               stall_raw;
  logic                               stall;
  logic                               flush;

  // EX sources pick the forwarding stage; ID sources look for load-use hazards.
  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    hazard_src_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .FWD_DEPTH  (FWD_DEPTH),
      .LOAD_STAGE (LOAD_STAGE)
    ) u_ex_match (
      .src_addr (ex_rs_addr_q[p*REG_ADDR_W +: REG_ADDR_W]),
      .src_used (ex_rs_used_q[p]),
      .sb       (sb_q),
      .fwd_sel  (fwd_sel[p*SEL_W +: SEL_W]),
      .load_hit (ex_load_hit_unused[p])
    );

    hazard_src_match #(
      .REG_ADDR_W (REG_ADDR_W),
      .FWD_DEPTH  (FWD_DEPTH),
      .LOAD_STAGE (LOAD_STAGE)
    ) u_id_match (
      .src_addr (id_rs_addr[p*REG_ADDR_W +: REG_ADDR_W]),
      .src_used (id_rs_used[p]),
      .sb       (sb_q),
      .fwd_sel  (id_fwd_sel_unused[p*SEL_W +: SEL_W]),
      .load_hit (id_load_hit[p])
    );
  end

  // A taken branch flushes and overrides any stall; reset holds flushes low.
  assign stall_raw      = id_valid && (|id_load_hit);
  assign stall          = stall_raw && !branch_taken;
  assign flush          = branch_taken && reset;
  assign pc_write_en    = !stall;
  assign if_id_write_en = !stall;
  assign id_ex_bubble   = stall;
  assign if_id_flush    = flush;
  assign id_ex_flush    = flush;
  assign ex_mem_flush   = flush;

  // Next scoreboard: shift older stages, insert ID (or a bubble) at stage 0, kill wrong-path EX.
  always_comb begin
    sb_d[0] = '{valid: id_valid && !stall_raw && !branch_taken,
                rd:    SB_RD_W'(id_rd),
                we:    id_reg_write,
                load:  id_mem_read};
    for (int k = 1; k <= int'(FWD_DEPTH); k++) begin
      sb_d[k] = sb_q[k-1];
    end
    if (branch_taken) begin
      sb_d[1].valid = 1'b0;
    end
    ex_rs_addr_d = id_rs_addr;
    ex_rs_used_d = id_rs_used;
  end

  // Scoreboard and EX source registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the scoreboard is a few entries of control state, so it is reset in full;
      // stale valid bits after reset would fabricate forwarding and stalls.
      sb_q         <= '{default: '0};
      ex_rs_addr_q <= '0;
      ex_rs_used_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every stage samples the pre-edge value of its neighbour.
      sb_q         <= sb_d;
      ex_rs_addr_q <= ex_rs_addr_d;
      ex_rs_used_q <= ex_rs_used_d;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Counters advance on effective stalls and on taken branches; both wrap naturally.
  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(stall);
    flush_cnt_d = flush_cnt_q + 32'(branch_taken);
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Testbench: tb_pipeline_hazard_unit
// Directed scenarios plus randomized traffic against a queue-based model of
// the in-flight instruction window.
`timescale 1ns/1ps
module tb_pipeline_hazard_unit;

  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned NUM_RD_PORTS = 2;
  localparam int unsigned FWD_DEPTH    = 2;
  localparam int unsigned LOAD_STAGE   = 2;
  localparam int unsigned SEL_W        = 2;

  logic                               clk = 1'b0;
  logic                               reset = 1'b0;
  logic                               id_valid;
  logic [NUM_RD_PORTS*REG_ADDR_W-1:0] id_rs_addr;
  logic [NUM_RD_PORTS-1:0]            id_rs_used;
  logic [REG_ADDR_W-1:0]              id_rd;
  logic                               id_reg_write;
  logic                               id_mem_read;
  logic                               branch_taken;
  logic                               pc_write_en;
  logic                               if_id_write_en;
  logic                               id_ex_bubble;
  logic                               if_id_flush;
  logic                               id_ex_flush;
  logic                               ex_mem_flush;
  logic [NUM_RD_PORTS*SEL_W-1:0]      fwd_sel;
  logic [31:0]                        stall_cnt;
  logic [31:0]                        flush_cnt;

  pipeline_hazard_unit #(
    .REG_ADDR_W   (REG_ADDR_W),
    .NUM_RD_PORTS (NUM_RD_PORTS),
    .FWD_DEPTH    (FWD_DEPTH),
    .LOAD_STAGE   (LOAD_STAGE)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_rs_addr     (id_rs_addr),
    .id_rs_used     (id_rs_used),
    .id_rd          (id_rd),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .branch_taken   (branch_taken),
    .pc_write_en    (pc_write_en),
    .if_id_write_en (if_id_write_en),
    .id_ex_bubble   (id_ex_bubble),
    .if_id_flush    (if_id_flush),
    .id_ex_flush    (id_ex_flush),
    .ex_mem_flush   (ex_mem_flush),
    .fwd_sel        (fwd_sel),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit valid;
    int rd;
    bit we;
    bit load;
  } inst_t;

  inst_t       inflight[$];            // [0] is in EX, larger index = older
  int          ex_src [NUM_RD_PORTS];
  bit          ex_use [NUM_RD_PORTS];
  int unsigned m_stalls;
  int unsigned m_flushes;

  // Current ID-stage stimulus.
  bit cur_valid, cur_we, cur_ld, cur_br;
  int cur_rd;
  int id_src [NUM_RD_PORTS];
  bit id_use [NUM_RD_PORTS];

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Does the instruction 'age' slots past ID write the register this source reads?
  function automatic bit produces(input int age, input int src, input bit used);
    if (age >= inflight.size()) return 1'b0;
    return used && (src != 0) && inflight[age].valid && inflight[age].we && (inflight[age].rd == src);
  endfunction

  function automatic bit model_load_use();
    if (!cur_valid) return 1'b0;
    for (int p = 0; p < NUM_RD_PORTS; p++)
      for (int j = 0; j <= int'(LOAD_STAGE) - 2; j++)
        if (j < inflight.size() && inflight[j].load && produces(j, id_src[p], id_use[p])) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_fwd(input int p);
    for (int k = 1; k <= int'(FWD_DEPTH); k++)
      if (produces(k, ex_src[p], ex_use[p])) return k;
    return 0;
  endfunction

  task automatic model_clear();
    inflight.delete();
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      ex_src[p] = 0;
      ex_use[p] = 1'b0;
    end
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_id(input bit v, input int s0, input bit u0, input int s1, input bit u1,
                        input int rd, input bit we, input bit ld, input bit br);
    cur_valid = v;  id_src[0] = s0; id_use[0] = u0; id_src[1] = s1; id_use[1] = u1;
    cur_rd = rd;    cur_we = we;    cur_ld = ld;    cur_br = br;
    id_valid     = v;
    id_rs_addr   = {REG_ADDR_W'(s1), REG_ADDR_W'(s0)};
    id_rs_used   = {u1, u0};
    id_rd        = REG_ADDR_W'(rd);
    id_reg_write = we;
    id_mem_read  = ld;
    branch_taken = br;
  endtask

  task automatic nop();
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // Compare every output with the model for the current inputs (mid-cycle).
  task automatic check_cycle(input string tag);
    bit st;
    st = model_load_use() && !cur_br;
    #1;
    for (int p = 0; p < NUM_RD_PORTS; p++)
      check($sformatf("%s fwd%0d", tag, p), 32'(fwd_sel[p*SEL_W +: SEL_W]), 32'(model_fwd(p)));
    check({tag, " pc_we"},   32'(pc_write_en),    32'(!st));
    check({tag, " ifid_we"}, 32'(if_id_write_en), 32'(!st));
    check({tag, " bubble"},  32'(id_ex_bubble),   32'(st));
    check({tag, " fl_ifid"}, 32'(if_id_flush),    32'(cur_br));
    check({tag, " fl_idex"}, 32'(id_ex_flush),    32'(cur_br));
    check({tag, " fl_exm"},  32'(ex_mem_flush),   32'(cur_br));
`ifdef HAZARD_PERF_CNT_EN
    check({tag, " stall_cnt"}, stall_cnt, m_stalls);
    check({tag, " flush_cnt"}, flush_cnt, m_flushes);
`else
    check({tag, " stall_cnt"}, stall_cnt, 32'd0);
    check({tag, " flush_cnt"}, flush_cnt, 32'd0);
`endif
  endtask

  // Clock edge: advance the model window exactly as the pipeline would move.
  task automatic tick();
    bit    st_raw;
    inst_t n;
    st_raw = model_load_use();
    @(posedge clk);
    n.valid = cur_valid && !st_raw && !cur_br;
    n.rd    = cur_rd;
    n.we    = cur_we;
    n.load  = cur_ld;
    inflight.push_front(n);
    if (cur_br && inflight.size() > 1) inflight[1].valid = 1'b0;
    while (inflight.size() > FWD_DEPTH + 1) void'(inflight.pop_back());
    ex_src = id_src;
    ex_use = id_use;
    if (st_raw && !cur_br) m_stalls++;
    if (cur_br) m_flushes++;
    @(negedge clk);
  endtask

  task automatic rst_checks(input string tag);
    check({tag, " fwd"},     32'(fwd_sel),        32'd0);
    check({tag, " pc_we"},   32'(pc_write_en),    32'd1);
    check({tag, " ifid_we"}, 32'(if_id_write_en), 32'd1);
    check({tag, " bubble"},  32'(id_ex_bubble),   32'd0);
    check({tag, " flushes"}, 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'd0);
    check({tag, " stall_cnt"}, stall_cnt, 32'd0);
    check({tag, " flush_cnt"}, flush_cnt, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic load_use_pair(input int r);
    set_id(1'b1, 1, 1'b1, 2, 1'b0, r, 1'b1, 1'b1, 1'b0);  check_cycle("lu_lw");  tick();
    set_id(1'b1, 0, 1'b0, r, 1'b1, 11, 1'b1, 1'b0, 1'b0); check_cycle("lu_st");  tick();
    check_cycle("lu_rel"); tick();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bit held;
    model_clear();
    // Reset state, with a branch request present that must not flush.
    set_id(1'b1, 5, 1'b1, 6, 1'b1, 7, 1'b1, 1'b1, 1'b1);
    #2;
    rst_checks("rst_init");
    nop();
    do_reset();

    // Single producer: add x5 reaches stage 1 while EX reads x5 on port 0.
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 5, 1'b1, 1'b0, 1'b0); check_cycle("sp0"); tick();
    set_id(1'b1, 5, 1'b1, 7, 1'b1, 8, 1'b1, 1'b0, 1'b0); check_cycle("sp1"); tick();
    nop(); check_cycle("sp2");
    check("sp fwd0", 32'(fwd_sel[0 +: SEL_W]), 32'd1);
    check("sp fwd1", 32'(fwd_sel[SEL_W +: SEL_W]), 32'd0);
    tick();

    // Youngest producer wins when x5 is in stages 1 and 2.
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0); check_cycle("yw0"); tick();
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1, 1'b0, 1'b0); check_cycle("yw1"); tick();
    set_id(1'b1, 5, 1'b0, 5, 1'b1, 0, 1'b0, 1'b0, 1'b0); check_cycle("yw2"); tick();
    nop(); check_cycle("yw3");
    check("yw fwd1", 32'(fwd_sel[SEL_W +: SEL_W]), 32'd1);
    check("yw fwd0", 32'(fwd_sel[0 +: SEL_W]), 32'd0);
    tick();

    // x0 never forwards.
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0); check_cycle("x0_0"); tick();
    set_id(1'b1, 0, 1'b1, 3, 1'b0, 0, 1'b0, 1'b0, 1'b0); check_cycle("x0_1"); tick();
    nop(); check_cycle("x0_2");
    check("x0 fwd0", 32'(fwd_sel[0 +: SEL_W]), 32'd0);
    tick();

    // Load-use: one stall cycle, then forwarding from stage 2.
    set_id(1'b1, 1, 1'b0, 2, 1'b0, 6, 1'b1, 1'b1, 1'b0); check_cycle("lu0"); tick();
    set_id(1'b1, 0, 1'b0, 6, 1'b1, 10, 1'b1, 1'b0, 1'b0); check_cycle("lu1");
    check("lu stall pc", 32'(pc_write_en), 32'd0);
    check("lu stall ifid", 32'(if_id_write_en), 32'd0);
    check("lu stall bubble", 32'(id_ex_bubble), 32'd1);
    tick();
    check_cycle("lu2");
    check("lu release pc", 32'(pc_write_en), 32'd1);
    check("lu release bubble", 32'(id_ex_bubble), 32'd0);
    tick();
    nop(); check_cycle("lu3");
    check("lu fwd1", 32'(fwd_sel[SEL_W +: SEL_W]), 32'd2);
    tick();

    // Flush beats stall; the killed loads must not forward or stall afterwards.
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 6, 1'b1, 1'b1, 1'b0); check_cycle("fb0"); tick();
    set_id(1'b1, 0, 1'b0, 6, 1'b1, 9, 1'b1, 1'b1, 1'b1); check_cycle("fb1");
    check("fb flushes", 32'({if_id_flush, id_ex_flush, ex_mem_flush}), 32'd7);
    check("fb pc", 32'(pc_write_en), 32'd1);
    check("fb bubble", 32'(id_ex_bubble), 32'd0);
    tick();
    set_id(1'b1, 9, 1'b1, 6, 1'b1, 12, 1'b0, 1'b0, 1'b0); check_cycle("fb2");
    check("fb st1 killed", 32'(fwd_sel[SEL_W +: SEL_W]), 32'd0);
    check("fb st0 killed", 32'(pc_write_en), 32'd1);
    tick();

    // Counters: three stall cycles from a clean reset.
    nop();
    do_reset();
    for (int i = 0; i < 3; i++) load_use_pair(6 + i);
    nop(); check_cycle("cnt");
`ifdef HAZARD_PERF_CNT_EN
    check("cnt stall3", stall_cnt, 32'd3);
`else
    check("cnt stall3", stall_cnt, 32'd0);
`endif
    tick();

    // Reset asserted in the middle of a stall drops it at once.
    set_id(1'b1, 1, 1'b0, 2, 1'b0, 4, 1'b1, 1'b1, 1'b0); check_cycle("rm0"); tick();
    set_id(1'b1, 4, 1'b1, 0, 1'b0, 13, 1'b1, 1'b0, 1'b0); check_cycle("rm1");
    check("rm stalled", 32'(id_ex_bubble), 32'd1);
    reset = 1'b0;
    #1;
    rst_checks("rst_mid");
    model_clear();
    @(negedge clk);
    reset = 1'b1;

    // Randomized traffic over a small register set to provoke many hits.
    held = 1'b0;
    for (int c = 0; c < 600; c++) begin
      bit v;
      if (held) begin
        set_id(cur_valid, id_src[0], id_use[0], id_src[1], id_use[1], cur_rd, cur_we, cur_ld,
               ($urandom_range(7) == 0));
      end else begin
        v = ($urandom_range(5) != 0);
        set_id(v, $urandom_range(7), v && $urandom_range(1), $urandom_range(7), v && $urandom_range(1),
               $urandom_range(7), $urandom_range(3) != 0, $urandom_range(2) == 0,
               ($urandom_range(7) == 0));
      end
      held = model_load_use() && !cur_br;
      check_cycle($sformatf("rnd%0d", c));
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
